sdram_req_queue: RTL and testbench

//  Client-side front end placed directly upstream of the SDRAM controller.
//  - Boots the controller, then buffers client read/write requests in a small FIFO.
//  - Issues requests one at a time using the controller's en/rdy protocol.
//  - Returns read data to the client as a single-cycle response pulse.

---
 rtl/sdram_req_queue.sv | 128 ++++++++++++
 tb/tb_sdram_req_queue.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_req_queue.sv
// Client request FIFO and one-at-a-time issue engine in front of the SDRAM
// controller: boots the controller, queues requests, returns read data.
module sdram_req_queue #(
  parameter int DATA_BITS  = 32,
  parameter int ADDR_BITS  = 13,
  parameter int DEPTH_LOG2 = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [DATA_BITS-1:0] rsp_rdata,
  output logic                 init_done,
  output logic                 busy,
  output logic                 err,
  output logic                 ctl_en,
  output logic                 ctl_we,
  output logic [ADDR_BITS-1:0] ctl_addr,
  output logic [DATA_BITS-1:0] ctl_wdata,
  input  logic                 ctl_rdy,
  input  logic                 ctl_valid,
  input  logic [DATA_BITS-1:0] ctl_rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int EW    = 1 + ADDR_BITS + DATA_BITS;

  typedef enum logic [2:0] {
    BOOT, WAIT_INIT, IDLE, ISSUE, WAIT_ACK, WAIT_DONE
  } state_t;

  state_t state, state_nx;

  logic [EW-1:0]       mem [DEPTH];
  logic [EW-1:0]       head;
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr, count;
  logic [TW-1:0]       tmo_cnt;
  logic                push, pop;
  logic                waiting, tmo_hit, capture;
  logic                got_rsp;

  assign count     = wr_ptr - rd_ptr;
  assign req_ready = (count != (DEPTH_LOG2+1)'(DEPTH));
  assign push      = req_valid && req_ready;
  assign head      = mem[rd_ptr[DEPTH_LOG2-1:0]];

  assign waiting = (state == WAIT_ACK) || (state == WAIT_DONE);
  assign tmo_hit = waiting && (tmo_cnt == TW'(TIMEOUT));
  // A timed-out request is dropped, so late read data is ignored.
  assign capture = waiting && ctl_valid && !tmo_hit;

  assign busy = (count != '0) || (state == ISSUE) || waiting;

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      BOOT:      state_nx = WAIT_INIT;
      WAIT_INIT: if (ctl_rdy) state_nx = IDLE;
      IDLE: begin
        if ((count != '0) && ctl_rdy) begin
          pop      = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE:     state_nx = WAIT_ACK;
      WAIT_ACK: begin
        if (tmo_hit)      state_nx = IDLE;
        else if (!ctl_rdy) state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tmo_hit) state_nx = IDLE;
        else if (ctl_rdy && (ctl_we || got_rsp)) state_nx = IDLE;
      end
      default:   state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {req_we, req_addr, req_wdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ctl_en    <= 1'b0;
      ctl_we    <= 1'b0;
      ctl_addr  <= '0;
      ctl_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      got_rsp   <= 1'b0;
      init_done <= 1'b0;
      err       <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      rsp_valid <= capture;
      ctl_en    <= (state == BOOT) || pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr                        <= rd_ptr + 1'b1;
        {ctl_we, ctl_addr, ctl_wdata} <= head;
        got_rsp                       <= 1'b0;
      end
      if (capture) begin
        rsp_rdata <= ctl_rdata;
        got_rsp   <= 1'b1;
      end
      if ((state == WAIT_INIT) && ctl_rdy) init_done <= 1'b1;
      if (tmo_hit) err <= 1'b1;
      if (state == ISSUE)           tmo_cnt <= '0;
      else if (waiting && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_req_queue.sv
// Directed bench for sdram_req_queue with a small behavioural SDRAM
// controller model and a vector table for single requests.
module tb_sdram_req_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [12:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        init_done, busy, err;
  logic        ctl_en, ctl_we;
  logic [12:0] ctl_addr;
  logic [31:0] ctl_wdata;
  logic        ctl_rdy = 1'b0;
  logic        ctl_valid = 1'b0;
  logic [31:0] ctl_rdata = '0;

  sdram_req_queue dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .init_done(init_done), .busy(busy), .err(err),
    .ctl_en(ctl_en), .ctl_we(ctl_we), .ctl_addr(ctl_addr),
    .ctl_wdata(ctl_wdata), .ctl_rdy(ctl_rdy), .ctl_valid(ctl_valid),
    .ctl_rdata(ctl_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [12:0] addr;
    logic [31:0] wdata;
  } op_t;

  typedef struct {
    logic        we;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic        exp_rsp;
    logic [31:0] exp_rdata;
  } vec_t;

  int checks = 0;
  int errors = 0;

  bit hold = 1'b1;
  bit stuck = 1'b0;
  bit model_on = 1'b0;
  bit [31:0] mmem [8192];

  op_t          issued [$];
  logic [31:0]  rsp_q [$];
  int           overlap = 0;
  logic         prev_en = 1'b0;

  // Controller model: busy for a few cycles per command, read data pulse.
  int   ms = 0;
  int   mcnt = 0;
  op_t  mop;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        ms = 0;
        ctl_valid = 1'b0;
        ctl_rdy = 1'b0;
      end else begin
        case (ms)
          0: begin
            ctl_rdy = !hold;
            if (ctl_en && model_on && !stuck) begin
              mop = {ctl_we, ctl_addr, ctl_wdata};
              if (ctl_we) mmem[ctl_addr] = ctl_wdata;
              ctl_rdy = 1'b0;
              mcnt = 2;
              ms = 1;
            end
          end
          1: begin
            mcnt--;
            if (mcnt == 0) begin
              if (!mop.we) begin
                ctl_valid = 1'b1;
                ctl_rdata = mmem[mop.addr];
              end
              ms = 2;
            end
          end
          default: begin
            ctl_valid = 1'b0;
            ctl_rdy = 1'b1;
            ms = 0;
          end
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ctl_en) begin
        issued.push_back({ctl_we, ctl_addr, ctl_wdata});
        if (prev_en) overlap++;
      end
      prev_en = ctl_en;
      if (rsp_valid) rsp_q.push_back(rsp_rdata);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tmo_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out", nm);
  endtask

  task automatic push(input logic we, input logic [12:0] a,
                      input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) tmo_fail("push_ready");
    else begin
      req_we = we;
      req_addr = a;
      req_wdata = d;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy) tmo_fail(nm);
  endtask

  task automatic wait_en(input string nm);
    int n = 0;
    while (!ctl_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ctl_en) tmo_fail(nm);
  endtask

  vec_t vt [7];
  int   lat;
  int   n;
  logic rdy_obs [5];

  initial begin
    vt[0] = '{1'b1, 13'h0123, 32'hDEADBEEF, 1'b0, 32'h0};
    vt[1] = '{1'b0, 13'h0123, 32'h0,        1'b1, 32'hDEADBEEF};
    vt[2] = '{1'b1, 13'h1FFF, 32'h12345678, 1'b0, 32'h0};
    vt[3] = '{1'b0, 13'h1FFF, 32'h0,        1'b1, 32'h12345678};
    vt[4] = '{1'b0, 13'h0000, 32'h0,        1'b1, 32'h00000000};
    vt[5] = '{1'b1, 13'h0800, 32'hA5A5A5A5, 1'b0, 32'h0};
    vt[6] = '{1'b0, 13'h0800, 32'h0,        1'b1, 32'hA5A5A5A5};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ctl_en", ctl_en, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 1);

    // Boot: one ctl_en pulse, init waits on a long-busy controller
    rst = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (ctl_en) n++;
    end
    chk("boot_pulses", n, 1);
    repeat (10000) @(negedge clk);
    chk("init_wait", init_done, 0);
    hold = 1'b0;
    repeat (3) @(negedge clk);
    chk("init_done", init_done, 1);
    model_on = 1'b1;
    issued.delete();
    rsp_q.delete();

    // Single requests from the table
    for (int i = 0; i < 7; i++) begin
      issued.delete();
      rsp_q.delete();
      push(vt[i].we, vt[i].addr, vt[i].wdata);
      lat = 0;
      while (!ctl_en && lat < 50) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("v%0d_latency", i), lat, 2);
      wait_idle($sformatf("v%0d_idle", i));
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_issued", i), issued.size(), 1);
      if (issued.size() > 0) begin
        chk($sformatf("v%0d_we", i), issued[0].we, vt[i].we);
        chk($sformatf("v%0d_addr", i), issued[0].addr, vt[i].addr);
        if (vt[i].we)
          chk($sformatf("v%0d_wdata", i), issued[0].wdata, vt[i].wdata);
      end
      chk($sformatf("v%0d_rsp_n", i), rsp_q.size(), vt[i].exp_rsp ? 1 : 0);
      if (vt[i].exp_rsp && rsp_q.size() > 0)
        chk($sformatf("v%0d_rdata", i), rsp_q[0], vt[i].exp_rdata);
    end

    // Fill with controller busy: ready falls after 4 pushes
    hold = 1'b1;
    repeat (3) @(negedge clk);
    issued.delete();
    for (int i = 0; i < 5; i++) begin
      rdy_obs[i] = req_ready;
      req_we = 1'b1;
      req_addr = 13'h10 + 13'(i);
      req_wdata = 32'h4000 + i;
      req_valid = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++)
      chk($sformatf("fill_ready%0d", i), rdy_obs[i], i < 4);
    chk("fill_busy", busy, 1);
    chk("fill_no_issue", issued.size(), 0);
    hold = 1'b0;
    wait_idle("drain_idle");
    repeat (2) @(negedge clk);
    chk("drain_n", issued.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < issued.size())
        chk($sformatf("drain_addr%0d", i), issued[i].addr, 13'h10 + 13'(i));
    chk("overlap", overlap, 0);

    // Refill while draining: order kept across pointer wrap
    hold = 1'b1;
    repeat (3) @(negedge clk);
    issued.delete();
    for (int i = 0; i < 4; i++) push(1'b1, 13'h20 + 13'(i), 32'h5000 + i);
    @(negedge clk);
    chk("full_ready", req_ready, 0);
    hold = 1'b0;
    for (int i = 4; i < 8; i++) push(1'b1, 13'h20 + 13'(i), 32'h5000 + i);
    wait_idle("wrap_idle");
    repeat (2) @(negedge clk);
    chk("wrap_n", issued.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < issued.size()) begin
        chk($sformatf("wrap_addr%0d", i), issued[i].addr, 13'h20 + 13'(i));
        chk($sformatf("wrap_data%0d", i), issued[i].wdata, 32'h5000 + i);
      end

    // Timeout: controller never acknowledges
    stuck = 1'b1;
    issued.delete();
    rsp_q.delete();
    push(1'b0, 13'h0055, 32'h0);
    @(negedge clk);
    wait_en("tmo_issue");
    n = 0;
    while (!err && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", n, 257);
    chk("tmo_err", err, 1);
    chk("tmo_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("tmo_no_rsp", rsp_q.size(), 0);
    chk("tmo_issued", issued.size(), 1);
    stuck = 1'b0;
    issued.delete();
    push(1'b0, 13'h0123, 32'h0);
    wait_idle("post_tmo_idle");
    repeat (2) @(negedge clk);
    chk("post_tmo_issued", issued.size(), 1);
    chk("post_tmo_rsp_n", rsp_q.size(), 1);
    if (rsp_q.size() > 0) chk("post_tmo_rdata", rsp_q[0], 32'hDEADBEEF);
    chk("err_sticky", err, 1);

    // Reset in the middle of a read
    rsp_q.delete();
    push(1'b0, 13'h0123, 32'h0);
    @(negedge clk);
    wait_en("mid_issue");
    rst = 1'b1;
    model_on = 1'b0;
    @(negedge clk);
    chk("mid_ctl", {ctl_en, ctl_we, ctl_addr, ctl_wdata}, 0);
    chk("mid_rsp", {rsp_valid, rsp_rdata}, 0);
    chk("mid_flags", {init_done, busy, err}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_no_rsp", rsp_q.size(), 0);
    chk("mid_err", err, 0);
    chk("mid_reinit", init_done, 1);
    chk("mid_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
